serial_parity_checker: RTL and testbench

SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

---
 rtl/serial_parity_checker.sv | 94 +++++++++
 tb/tb_serial_parity_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_W data bits (MSB first) followed by one parity bit.
// It reports the assembled word and a parity verdict, and keeps a saturating count of bad frames.
module serial_parity_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inp,
    input  logic              in_valid,
    input  logic              odd_mode,
    input  logic              clr_cnt,
    output logic              par,
    output logic              busy,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid,
    output logic              par_err,
    output logic [CNT_W-1:0]  err_cnt
);

    // state  | meaning
    // IDLE   | waiting for the first data bit of a frame
    // DATA   | shifting in the remaining data bits
    // PARITY | next accepted bit is the frame's parity bit
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int BC_W = $clog2(DATA_W + 1);

    state_t            state;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] sreg;
    logic              odd_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            odd_l      <= 1'b0;
            par        <= 1'b0;
            busy       <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            par_err    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            word_valid <= 1'b0;

            // The count follows the registered verdict, so clear can win over an increment.
            if (clr_cnt)
                err_cnt <= '0;
            else if (word_valid && par_err && (err_cnt != {CNT_W{1'b1}}))
                err_cnt <= err_cnt + 1'b1;

            if (in_valid) begin
                case (state)
                    IDLE: begin
                        sreg    <= {{(DATA_W-1){1'b0}}, inp};
                        par     <= inp;
                        odd_l   <= odd_mode;
                        bit_cnt <= BC_W'(1);
                        busy    <= 1'b1;
                        state   <= DATA;
                    end
                    DATA: begin
                        sreg    <= {sreg[DATA_W-2:0], inp};
                        par     <= par ^ inp;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BC_W'(DATA_W - 1))
                            state <= PARITY;
                    end
                    PARITY: begin
                        word_out   <= sreg;
                        word_valid <= 1'b1;
                        par_err    <= ((par ^ inp) != odd_l);
                        bit_cnt    <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                    default: begin
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Randomized and directed bench for serial_parity_checker against a queue-based frame model.
module tb_serial_parity_checker;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              inp = 1'b0;
    logic              in_valid = 1'b0;
    logic              odd_mode = 1'b0;
    logic              clr_cnt = 1'b0;
    logic              par;
    logic              busy;
    logic [DATA_W-1:0] word_out;
    logic              word_valid;
    logic              par_err;
    logic [CNT_W-1:0]  err_cnt;

    serial_parity_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .odd_mode(odd_mode),
        .clr_cnt(clr_cnt), .par(par), .busy(busy), .word_out(word_out),
        .word_valid(word_valid), .par_err(par_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wv_cyc = 0;
    bit clr_en = 1'b0;

    // reference model: bits of the frame in progress plus expected output values
    int q[$];
    bit m_odd;
    bit m_par;
    bit m_busy;
    bit m_wv;
    bit m_perr;
    int m_word;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit q_xor();
        bit x = 1'b0;
        foreach (q[i]) x ^= q[i][0];
        return x;
    endfunction

    task automatic model_reset();
        q.delete();
        m_odd = 0; m_par = 0; m_busy = 0; m_wv = 0; m_perr = 0; m_word = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        int w;
        if (clr_cnt) m_cnt = 0;
        else if (m_wv && m_perr && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        m_wv = 0;
        if (in_valid) begin
            if (q.size() < DATA_W) begin
                if (q.size() == 0) m_odd = odd_mode;
                q.push_back(int'(inp));
                m_par = q_xor();
            end else begin
                w = 0;
                foreach (q[i]) w = (w << 1) | q[i];
                m_word = w;
                m_perr = ((q_xor() ^ inp) != m_odd);
                m_wv = 1;
                q.delete();
            end
        end
        m_busy = (q.size() > 0);
    endtask

    task automatic check_outputs();
        chk("word_valid", word_valid, m_wv);
        chk("busy", busy, m_busy);
        chk("par", par, m_par);
        chk("err_cnt", err_cnt, m_cnt);
        chk("word_out", word_out, m_word);
        chk("par_err", par_err, m_perr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        check_outputs();
        if (word_valid) wv_cyc = cyc;
    endtask

    task automatic send_bit(input bit b, input bit odd, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 0; inp = 1'($urandom); odd_mode = 1'($urandom);
            clr_cnt = clr_en && ($urandom_range(0, 7) == 0);
            step();
        end
        in_valid = 1; inp = b; odd_mode = odd;
        clr_cnt = clr_en && ($urandom_range(0, 7) == 0);
        step();
        in_valid = 0; clr_cnt = 0;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w, input bit pbit, input bit odd,
                              input int gap, input bit rnd);
        for (int i = DATA_W - 1; i >= 0; i--)
            send_bit(w[i], (i == DATA_W - 1) ? odd : 1'($urandom),
                     rnd ? int'($urandom_range(0, gap)) : gap);
        send_bit(pbit, 1'($urandom), rnd ? int'($urandom_range(0, gap)) : gap);
    endtask

    task automatic idle_step(input bit clr);
        in_valid = 0; clr_cnt = clr;
        step();
        clr_cnt = 0;
    endtask

    initial begin
        int t1;
        model_reset();
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_err_cnt", err_cnt, 0);
        chk("reset_word_out", word_out, 0);
        @(negedge clk); rst = 0;

        // 0x84 even/odd parity cases
        send_frame(8'h84, 0, 0, 0, 0);
        chk("h84_even_word", word_out, 8'h84);
        chk("h84_even_perr", par_err, 0);
        idle_step(0);
        chk("wv_one_cycle", word_valid, 0);
        send_frame(8'h84, 1, 1, 0, 0);
        chk("h84_odd_perr", par_err, 0);
        send_frame(8'h84, 1, 0, 0, 0);
        chk("h84_bad_perr", par_err, 1);
        idle_step(0);
        chk("h84_bad_cnt", err_cnt, 1);

        // gapped frame
        send_frame(8'hA5, 0, 0, 3, 0);
        chk("hA5_word", word_out, 8'hA5);
        chk("hA5_perr", par_err, 0);
        idle_step(1);

        // back-to-back frames
        send_frame(8'h01, 0, 0, 0, 0);
        t1 = wv_cyc;
        chk("b2b_first_perr", par_err, 1);
        send_frame(8'h80, 1, 0, 0, 0);
        chk("b2b_gap", wv_cyc - t1, 9);
        chk("b2b_second_perr", par_err, 0);
        idle_step(0);
        chk("b2b_cnt", err_cnt, 1);

        // saturation then clear overriding an increment
        idle_step(1);
        for (int k = 0; k < 5; k++) begin
            send_frame(8'h01, 0, 0, 0, 0);
            idle_step(0);
            chk("sat_cnt", err_cnt, (k < 3) ? k + 1 : 3);
        end
        send_frame(8'h01, 0, 0, 0, 0);
        idle_step(1);
        chk("clr_override", err_cnt, 0);

        // asynchronous reset mid-frame
        for (int i = 7; i >= 5; i--) send_bit(1'(8'h5A >> i), 0, 0);
        #2 rst = 1;
        #1;
        model_reset();
        chk("arst_busy", busy, 0);
        chk("arst_par", par, 0);
        chk("arst_word_out", word_out, 0);
        chk("arst_wv", word_valid, 0);
        chk("arst_perr", par_err, 0);
        chk("arst_cnt", err_cnt, 0);
        @(negedge clk); rst = 0;
        idle_step(0);
        send_frame(8'h3C, 0, 0, 0, 0);
        chk("after_rst_word", word_out, 8'h3C);
        chk("after_rst_perr", par_err, 0);

        // random frames with gaps, mid-frame odd_mode changes and random clears
        clr_en = 1;
        for (int f = 0; f < 150; f++)
            send_frame(DATA_W'($urandom), 1'($urandom), 1'($urandom), 2, 1);
        clr_en = 0;
        idle_step(0);
        idle_step(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
